imem_loader: RTL and testbench
==============================

Name: imem_loader

Overview:
- Program loader that sits directly upstream of the instruction memory and the CPU core.
- Accepts a byte stream on a valid/ready handshake, assembles 12-bit instructions, and writes them sequentially into instruction memory from address 0.
- Verifies a trailing XOR checksum.
- Holds the CPU in reset until a program has loaded successfully.

Parameters:
- ADDR_W, 10, instruction memory address width.
- INSTR_W, 12, instruction width: opcode [11:8], operand [7:0].
- MAX_WORDS, 1024, largest legal program length in words.

Ports:
- clk  input  1  system clock; sole clock domain.
- reset_loader  input  1  synchronous, active-high reset.
- start  input  1  one-cycle pulse; begins a load from IDLE, DONE or ERROR.
- rx_data  input  8  incoming byte.
- rx_valid  input  1  rx_data is valid this cycle.
- rx_ready  output  1  loader accepts a byte; transfer occurs when rx_valid && rx_ready at the clk edge.
- imem_we  output  1  instruction memory write strobe, one-cycle pulse.
- imem_waddr  output  ADDR_W  write address.
- imem_wdata  output  INSTR_W  write data.
- cpu_hold  output  1  drives the CPU reset; high while no valid program is loaded.
- load_done  output  1  level; program loaded and checksum passed.
- load_error  output  1  level; last load failed.
- words_loaded  output  11  count of words written in the current or last load.

Behaviour:
- Reset (synchronous):
  - state=IDLE, rx_ready=0, imem_we=0, imem_waddr=0, imem_wdata=0.
  - cpu_hold=1, load_done=0, load_error=0, words_loaded=0.
  - Reset mid-load aborts the load. Memory already written is left as is.
- Frame format, in byte order:
  - LEN_LO, LEN_HI: little-endian word count N; only LEN_HI[2:0] is used.
  - Then N pairs of (operand byte, opcode byte).
  - Then one checksum byte.
- Checksum: XOR of every byte preceding it, including the length bytes.
- States:
  - IDLE: rx_ready=0. start -> LEN_LO; clears the checksum accumulator and words_loaded, sets cpu_hold=1, load_done=0, load_error=0.
  - LEN_LO: rx_ready=1. On transfer, latch N[7:0] -> LEN_HI.
  - LEN_HI: rx_ready=1. On transfer, form N.
    - N==0, N>MAX_WORDS, or LEN_HI[7:3]!=0 -> ERROR.
    - Otherwise -> INS_LO.
  - INS_LO: rx_ready=1. On transfer, latch the operand byte -> INS_HI.
  - INS_HI: rx_ready=1. On transfer:
    - byte[7:4]!=0 -> ERROR.
    - Otherwise imem_wdata={byte[3:0], operand} -> WRITE.
  - WRITE: rx_ready=0 for exactly one cycle; imem_we=1 with imem_waddr=words_loaded.
    - Next cycle: words_loaded+1.
    - If words_loaded+1==N -> CHECK, else -> INS_LO.
  - CHECK: rx_ready=1. On transfer:
    - byte==accumulator -> DONE.
    - Otherwise -> ERROR.
  - DONE: rx_ready=0, load_done=1, cpu_hold=0 (registered: drops the cycle after entering DONE). start -> new load (LEN_LO as above).
  - ERROR: rx_ready=0, load_error=1, cpu_hold=1. start -> new load (LEN_LO as above).
- Throughput: one byte per cycle in any state with rx_ready=1, so each word costs 3 cycles minimum.
- Backpressure/stalls: rx_valid low holds the state; no timeout.
- rx_data is ignored when no transfer occurs.
- start outside IDLE/DONE/ERROR is ignored.
- Address never wraps: N<=MAX_WORDS bounds imem_waddr to 0..MAX_WORDS-1.
- imem_we never asserts outside WRITE. On the error paths, no write occurs for the offending word.
- Accumulator updates on every accepted byte except the checksum byte itself.

Test Plan:
1. Reset, start, send 02 00 A5 03 01 09 AC -> two writes:
   - addr0 data 0x3A5, then addr1 data 0x901.
   - Then load_done=1, cpu_hold=0, words_loaded=2, load_error=0.
2. Same frame with checksum 0xAD -> both writes occur, then load_error=1, cpu_hold=1, load_done=0.
3. Send 00 00 (N=0) -> ERROR immediately, no imem_we. Also send 01 04 (N=1025) -> ERROR.
4. Opcode byte 0x13 in INS_HI -> ERROR, no write for that word; words_loaded holds its prior count.
5. Frame from test 1 with rx_valid toggled randomly:
   - Identical writes and result.
   - rx_ready=0 exactly during each WRITE cycle.
   - No byte lost or duplicated.
6. Assert reset_loader while in INS_HI, then start and send a full valid frame:
   - On reset, all outputs return to their reset values.
   - The new load completes cleanly from address 0.
   - start pulses while mid-frame are ignored.

Source files
------------

// File: rtl/imem_loader.sv
// imem_loader: receives a byte-stream program frame, assembles 12-bit
// instructions, writes them into instruction memory from address 0,
// verifies a trailing XOR checksum and releases the CPU only on success.
module imem_loader #(
   parameter int ADDR_W    = 10,
   parameter int INSTR_W   = 12,
   parameter int MAX_WORDS = 1024
) (
   input  logic               clk,
   input  logic               reset_loader,
   input  logic               start,
   input  logic [7:0]         rx_data,
   input  logic               rx_valid,
   output logic               rx_ready,
   output logic               imem_we,
   output logic [ADDR_W-1:0]  imem_waddr,
   output logic [INSTR_W-1:0] imem_wdata,
   output logic               cpu_hold,
   output logic               load_done,
   output logic               load_error,
   output logic [10:0]        words_loaded
);

   localparam logic [10:0] MAX_N = 11'(MAX_WORDS);

   typedef enum logic [3:0] {
      S_IDLE, S_LEN_LO, S_LEN_HI, S_INS_LO, S_INS_HI,
      S_WRITE, S_CHECK, S_DONE, S_ERROR
   } state_t;

   state_t      state, state_nxt;
   logic [7:0]  len_lo;
   logic [10:0] word_count;
   logic [7:0]  operand;
   logic [7:0]  acc;
   logic        xfer;
   logic        start_ok;
   logic [10:0] len_rx;
   logic        len_bad;

   assign xfer     = rx_valid && rx_ready;
   assign start_ok = start && (state == S_IDLE || state == S_DONE || state == S_ERROR);
   assign len_rx   = {rx_data[2:0], len_lo};
   // Only LEN_HI[2:0] carries length; any higher bit set is a malformed frame.
   assign len_bad  = (rx_data[7:3] != 5'd0) || (len_rx == 11'd0) || (len_rx > MAX_N);

   // State register.
   always_ff @(posedge clk) begin
      if (reset_loader) state <= S_IDLE;
      else              state <= state_nxt;
   end

   // Next-state decode and state-derived strobes/levels.
   always_comb begin
      state_nxt  = state;
      rx_ready   = 1'b0;
      imem_we    = 1'b0;
      load_done  = 1'b0;
      load_error = 1'b0;
      case (state)
         S_IDLE: begin
            if (start) state_nxt = S_LEN_LO;
         end
         S_LEN_LO: begin
            rx_ready = 1'b1;
            if (rx_valid) state_nxt = S_LEN_HI;
         end
         S_LEN_HI: begin
            rx_ready = 1'b1;
            if (rx_valid) state_nxt = len_bad ? S_ERROR : S_INS_LO;
         end
         S_INS_LO: begin
            rx_ready = 1'b1;
            if (rx_valid) state_nxt = S_INS_HI;
         end
         S_INS_HI: begin
            rx_ready = 1'b1;
            if (rx_valid) state_nxt = (rx_data[7:4] != 4'd0) ? S_ERROR : S_WRITE;
         end
         S_WRITE: begin
            imem_we   = 1'b1;
            state_nxt = (words_loaded + 11'd1 == word_count) ? S_CHECK : S_INS_LO;
         end
         S_CHECK: begin
            rx_ready = 1'b1;
            if (rx_valid) state_nxt = (rx_data == acc) ? S_DONE : S_ERROR;
         end
         S_DONE: begin
            load_done = 1'b1;
            if (start) state_nxt = S_LEN_LO;
         end
         S_ERROR: begin
            load_error = 1'b1;
            if (start) state_nxt = S_LEN_LO;
         end
         default: state_nxt = S_IDLE;
      endcase
   end

   // Control outputs: write address/data, word counter and CPU hold.
   always_ff @(posedge clk) begin
      if (reset_loader) begin
         imem_waddr   <= '0;
         imem_wdata   <= '0;
         cpu_hold     <= 1'b1;
         words_loaded <= '0;
      end else begin
         // cpu_hold is registered so it falls one cycle after DONE is entered.
         cpu_hold <= !(state == S_DONE && !start);
         if (start_ok) words_loaded <= '0;
         else if (state == S_WRITE) words_loaded <= words_loaded + 11'd1;
         // Address and data are staged on the opcode byte so they are stable
         // throughout the single WRITE cycle.
         if (xfer && state == S_INS_HI && rx_data[7:4] == 4'd0) begin
            imem_waddr <= words_loaded[ADDR_W-1:0];
            imem_wdata <= INSTR_W'({rx_data[3:0], operand});
         end
      end
   end

   // Frame datapath: length, operand capture and running XOR checksum.
   always_ff @(posedge clk) begin
      if (start_ok) acc <= 8'd0;
      else if (xfer && state != S_CHECK) acc <= acc ^ rx_data;
      if (xfer && state == S_LEN_LO) len_lo <= rx_data;
      if (xfer && state == S_LEN_HI) word_count <= len_rx;
      if (xfer && state == S_INS_LO) operand <= rx_data;
   end

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader with a write scoreboard.
module tb_imem_loader;

   logic        clk = 1'b0;
   logic        reset_loader;
   logic        start;
   logic [7:0]  rx_data;
   logic        rx_valid;
   logic        rx_ready;
   logic        imem_we;
   logic [9:0]  imem_waddr;
   logic [11:0] imem_wdata;
   logic        cpu_hold;
   logic        load_done;
   logic        load_error;
   logic [10:0] words_loaded;

   typedef struct packed {
      logic [9:0]  addr;
      logic [11:0] data;
   } wr_t;

   wr_t         exp_q[$];
   int          n_assert = 0;
   int          n_fail   = 0;
   logic [7:0]  frame[$];

   imem_loader dut (
      .clk(clk), .reset_loader(reset_loader), .start(start),
      .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
      .imem_we(imem_we), .imem_waddr(imem_waddr), .imem_wdata(imem_wdata),
      .cpu_hold(cpu_hold), .load_done(load_done), .load_error(load_error),
      .words_loaded(words_loaded)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Write monitor: every imem_we must match the next expected write.
   always @(negedge clk) begin
      if (imem_we === 1'b1) begin
         check("rx_ready_in_write", {31'd0, rx_ready}, 32'd0);
         if (exp_q.size() == 0) begin
            check("unexpected_write", {22'd0, imem_waddr}, 32'hFFFF_FFFF);
         end else begin
            wr_t e;
            e = exp_q.pop_front();
            check("write_addr", {22'd0, imem_waddr}, {22'd0, e.addr});
            check("write_data", {20'd0, imem_wdata}, {20'd0, e.data});
         end
      end
   end

   task automatic pulse_start();
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
   endtask

   task automatic send_byte(input logic [7:0] b, input bit gaps);
      int waits = 0;
      if (gaps) begin
         while ($urandom_range(0, 1) == 1) begin
            rx_valid = 1'b0;
            rx_data  = 8'($urandom);
            @(negedge clk);
         end
      end
      rx_valid = 1'b1;
      rx_data  = b;
      while (rx_ready !== 1'b1 && waits < 50) begin
         @(negedge clk);
         waits++;
      end
      if (rx_ready !== 1'b1) check("rx_ready_timeout", {31'd0, rx_ready}, 32'd1);
      @(negedge clk);
      rx_valid = 1'b0;
      rx_data  = 8'($urandom);
   endtask

   task automatic send_frame(input bit gaps);
      foreach (frame[i]) send_byte(frame[i], gaps);
   endtask

   task automatic check_reset_values();
      check("rst_rx_ready", {31'd0, rx_ready}, 32'd0);
      check("rst_imem_we", {31'd0, imem_we}, 32'd0);
      check("rst_waddr", {22'd0, imem_waddr}, 32'd0);
      check("rst_wdata", {20'd0, imem_wdata}, 32'd0);
      check("rst_cpu_hold", {31'd0, cpu_hold}, 32'd1);
      check("rst_load_done", {31'd0, load_done}, 32'd0);
      check("rst_load_error", {31'd0, load_error}, 32'd0);
      check("rst_words", {21'd0, words_loaded}, 32'd0);
   endtask

   task automatic check_done(input string tag, input logic [10:0] words);
      check({tag, "_done"}, {31'd0, load_done}, 32'd1);
      check({tag, "_error"}, {31'd0, load_error}, 32'd0);
      check({tag, "_hold_first_cycle"}, {31'd0, cpu_hold}, 32'd1);
      check({tag, "_words"}, {21'd0, words_loaded}, {21'd0, words});
      @(negedge clk);
      check({tag, "_hold_released"}, {31'd0, cpu_hold}, 32'd0);
      check({tag, "_queue_empty"}, exp_q.size(), 32'd0);
   endtask

   task automatic check_error(input string tag, input logic [10:0] words);
      @(negedge clk);
      check({tag, "_error"}, {31'd0, load_error}, 32'd1);
      check({tag, "_done"}, {31'd0, load_done}, 32'd0);
      check({tag, "_hold"}, {31'd0, cpu_hold}, 32'd1);
      check({tag, "_words"}, {21'd0, words_loaded}, {21'd0, words});
      check({tag, "_queue_empty"}, exp_q.size(), 32'd0);
   endtask

   initial begin
      logic [7:0]  ck;
      logic [11:0] d;
      reset_loader = 1'b1;
      start        = 1'b0;
      rx_valid     = 1'b0;
      rx_data      = 8'h00;
      repeat (3) @(negedge clk);
      check_reset_values();
      reset_loader = 1'b0;
      @(negedge clk);

      // Test 1: valid two-word frame.
      pulse_start();
      check("t1_ready_after_start", {31'd0, rx_ready}, 32'd1);
      exp_q.push_back('{addr: 10'd0, data: 12'h3A5});
      exp_q.push_back('{addr: 10'd1, data: 12'h901});
      frame = '{8'h02, 8'h00, 8'hA5, 8'h03, 8'h01, 8'h09, 8'hAC};
      send_frame(1'b0);
      check_done("t1", 11'd2);

      // Test 2: bad checksum after both writes.
      pulse_start();
      exp_q.push_back('{addr: 10'd0, data: 12'h3A5});
      exp_q.push_back('{addr: 10'd1, data: 12'h901});
      frame = '{8'h02, 8'h00, 8'hA5, 8'h03, 8'h01, 8'h09, 8'hAD};
      send_frame(1'b0);
      check_error("t2", 11'd2);

      // Test 3: illegal lengths (0, 1025, LEN_HI bit 3 set).
      pulse_start();
      frame = '{8'h00, 8'h00};
      send_frame(1'b0);
      check_error("t3_len0", 11'd0);
      pulse_start();
      frame = '{8'h01, 8'h04};
      send_frame(1'b0);
      check_error("t3_len1025", 11'd0);
      pulse_start();
      frame = '{8'h01, 8'h08};
      send_frame(1'b0);
      check_error("t3_lenhi_bit3", 11'd0);

      // Test 4: bad opcode byte on the second word.
      pulse_start();
      exp_q.push_back('{addr: 10'd0, data: 12'h3A5});
      frame = '{8'h02, 8'h00, 8'hA5, 8'h03, 8'h77, 8'h13};
      send_frame(1'b0);
      check_error("t4", 11'd1);

      // Test 5: valid frame with random valid gaps.
      for (int rep = 0; rep < 3; rep++) begin
         pulse_start();
         exp_q.push_back('{addr: 10'd0, data: 12'h3A5});
         exp_q.push_back('{addr: 10'd1, data: 12'h901});
         frame = '{8'h02, 8'h00, 8'hA5, 8'h03, 8'h01, 8'h09, 8'hAC};
         send_frame(1'b1);
         check_done("t5", 11'd2);
      end

      // Maximum-length program: 1024 words, last address 1023.
      pulse_start();
      frame = '{8'h00, 8'h04};
      ck = 8'h04;
      for (int i = 0; i < 1024; i++) begin
         d = 12'($urandom);
         exp_q.push_back('{addr: 10'(i), data: d});
         frame.push_back(d[7:0]);
         frame.push_back({4'h0, d[11:8]});
         ck = ck ^ d[7:0] ^ {4'h0, d[11:8]};
      end
      frame.push_back(ck);
      send_frame(1'b0);
      check_done("tmax", 11'd1024);

      // Test 6: reset mid-load, then clean reload with ignored start pulses.
      pulse_start();
      frame = '{8'h02, 8'h00, 8'hA5};
      send_frame(1'b0);
      reset_loader = 1'b1;
      @(negedge clk);
      check_reset_values();
      reset_loader = 1'b0;
      @(negedge clk);
      pulse_start();
      exp_q.push_back('{addr: 10'd0, data: 12'h3A5});
      exp_q.push_back('{addr: 10'd1, data: 12'h901});
      send_byte(8'h02, 1'b0);
      send_byte(8'h00, 1'b0);
      pulse_start();
      send_byte(8'hA5, 1'b0);
      pulse_start();
      check("t6_words_mid", {21'd0, words_loaded}, 32'd0);
      frame = '{8'h03, 8'h01, 8'h09, 8'hAC};
      send_frame(1'b0);
      check_done("t6", 11'd2);

      repeat (2) @(negedge clk);
      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
